gaussian_row_filter: RTL and testbench



---
 rtl/gaussian_row_filter.sv | 178 +++++++++++++++++
 tb/tb_gaussian_row_filter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_row_filter.sv
// Horizontal 5-tap binomial Gaussian filter, kernel [1 4 6 4 1]/16.
// Works on a raster line stream framed by sol/eol and replicates the
// border pixels at both line edges. The output can be re-centred to
// two's complement for the signed DoG stage downstream.
module gaussian_row_filter #(
    parameter int DATA_W     = 8,
    parameter int SIGNED_OUT = 1,
    parameter int ROUND      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_sol,
    input  logic              din_eol,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_sol,
    output logic              dout_eol
);

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH1, FLUSH2} state_t;

    localparam int SUM_W = DATA_W + 4;
    localparam logic [SUM_W-1:0]  RND      = (ROUND != 0) ? SUM_W'(8) : '0;
    localparam logic [DATA_W-1:0] MSB_FLIP = (SIGNED_OUT != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    state_t state, state_next;

    // tap1 is the most recently accepted pixel, tap4 the oldest
    logic [DATA_W-1:0] tap1, tap2, tap3, tap4;
    logic              first_pend;
    logic              single_px;

    logic              flushing, accept, start_line;
    logic              load_en, shift_en;
    logic              produce, produce_sol, produce_eol;
    logic [DATA_W-1:0] tap_new;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] result_raw, result;
    logic [3:0]        frac_unused;

    assign flushing   = (state == FLUSH1) || (state == FLUSH2);
    assign din_ready  = clk_en & ~rst & ~flushing;
    assign accept     = din_valid & din_ready;
    assign start_line = accept & din_sol;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    // Next-state logic; a sol pixel always restarts framing, eol always ends it
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_line) begin
                    state_next = din_eol ? FLUSH1 : FILL;
                end
            end
            FILL, RUN: begin
                if (accept) begin
                    if (din_eol) begin
                        state_next = FLUSH1;
                    end else if (din_sol) begin
                        state_next = FILL;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            FLUSH1:  state_next = FLUSH2;
            FLUSH2:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode; during flush the last pixel is replicated as the newest tap
    always_comb begin
        load_en     = start_line;
        shift_en    = 1'b0;
        produce     = 1'b0;
        produce_sol = 1'b0;
        produce_eol = 1'b0;
        tap_new     = din;
        case (state)
            FILL: begin
                shift_en = accept & ~din_sol;
            end
            RUN: begin
                shift_en    = accept & ~din_sol;
                produce     = accept & ~din_sol;
                produce_sol = first_pend;
            end
            FLUSH1: begin
                shift_en    = 1'b1;
                tap_new     = tap1;
                produce     = 1'b1;
                produce_sol = first_pend;
                produce_eol = single_px;
            end
            FLUSH2: begin
                tap_new     = tap1;
                produce     = ~single_px;
                produce_sol = first_pend;
                produce_eol = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign sum = {4'b0, tap4}
               + ({4'b0, tap3} << 2)
               + ({4'b0, tap2} << 2) + ({4'b0, tap2} << 1)
               + ({4'b0, tap1} << 2)
               + {4'b0, tap_new}
               + RND;

    assign {result_raw, frac_unused} = sum;
    assign result = result_raw ^ MSB_FLIP;

    // Pixel window; a sol pixel fills every tap so the left border is replicated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap1       <= '0;
            tap2       <= '0;
            tap3       <= '0;
            tap4       <= '0;
            first_pend <= 1'b0;
            single_px  <= 1'b0;
        end else if (clk_en) begin
            if (load_en) begin
                tap1       <= din;
                tap2       <= din;
                tap3       <= din;
                tap4       <= din;
                first_pend <= 1'b1;
                single_px  <= din_eol;
            end else begin
                if (shift_en) begin
                    tap1 <= tap_new;
                    tap2 <= tap1;
                    tap3 <= tap2;
                    tap4 <= tap3;
                end
                if (produce) begin
                    first_pend <= 1'b0;
                end
            end
        end
    end

    // Registered outputs; dout_valid is a single enabled-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sol   <= 1'b0;
            dout_eol   <= 1'b0;
        end else if (clk_en) begin
            dout_valid <= produce;
            dout_sol   <= produce & produce_sol;
            dout_eol   <= produce & produce_eol;
            if (produce) begin
                dout <= result;
            end
        end
    end

endmodule

// File: tb/tb_gaussian_row_filter.sv
// Directed self-checking bench for gaussian_row_filter.
// Three instances share the input stream: unsigned/rounded, signed/rounded
// and unsigned/truncated.
module tb_gaussian_row_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkEn;
    logic [7:0] din;
    logic       dinValid, dinSol, dinEol;

    logic       dutReady, signedReady, truncReady;
    logic [7:0] dutOut, signedOut, truncOut;
    logic       dutValid, signedValid, truncValid;
    logic       dutSol, signedSol, truncSol;
    logic       dutEol, signedEol, truncEol;

    int errors = 0;
    int checks = 0;
    bit toggleEn = 1'b0;

    logic [9:0] obsMain[$];
    logic [9:0] obsSigned[$];
    logic [9:0] obsTrunc[$];
    logic [9:0] expQ[$];
    logic [7:0] lineQ[$];
    logic [7:0] valQ[$];

    always #5 clk = ~clk;

    gaussian_row_filter #(.DATA_W(8), .SIGNED_OUT(0), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .clk_en(clkEn),
        .din(din), .din_valid(dinValid), .din_sol(dinSol), .din_eol(dinEol),
        .din_ready(dutReady), .dout(dutOut), .dout_valid(dutValid),
        .dout_sol(dutSol), .dout_eol(dutEol)
    );

    gaussian_row_filter #(.DATA_W(8), .SIGNED_OUT(1), .ROUND(1)) dutSigned (
        .clk(clk), .rst(rst), .clk_en(clkEn),
        .din(din), .din_valid(dinValid), .din_sol(dinSol), .din_eol(dinEol),
        .din_ready(signedReady), .dout(signedOut), .dout_valid(signedValid),
        .dout_sol(signedSol), .dout_eol(signedEol)
    );

    gaussian_row_filter #(.DATA_W(8), .SIGNED_OUT(0), .ROUND(0)) dutTrunc (
        .clk(clk), .rst(rst), .clk_en(clkEn),
        .din(din), .din_valid(dinValid), .din_sol(dinSol), .din_eol(dinEol),
        .din_ready(truncReady), .dout(truncOut), .dout_valid(truncValid),
        .dout_sol(truncSol), .dout_eol(truncEol)
    );

    // Consumers: capture each output once, qualified by clk_en, away from the active edge
    always @(negedge clk) begin
        if (!rst && clkEn && dutValid)    obsMain.push_back({dutOut, dutSol, dutEol});
        if (!rst && clkEn && signedValid) obsSigned.push_back({signedOut, signedSol, signedEol});
        if (!rst && clkEn && truncValid)  obsTrunc.push_back({truncOut, truncSol, truncEol});
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle; clk_en either held high or toggled every cycle
    task automatic tick(output bit acc);
        if (toggleEn) clkEn = ~clkEn;
        else          clkEn = 1'b1;
        #1;
        acc = dinValid & dutReady;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        dinValid = 1'b0;
        dinSol   = 1'b0;
        dinEol   = 1'b0;
        repeat (n) tick(acc);
    endtask

    // Present one pixel and hold it until accepted (bounded)
    task automatic applyStimulus(input logic [7:0] px, input bit sol, input bit eol);
        bit acc = 1'b0;
        din      = px;
        dinSol   = sol;
        dinEol   = eol;
        dinValid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) tick(acc);
        checkOutput("pixel accepted", 32'(acc), 32'd1);
        dinValid = 1'b0;
        dinSol   = 1'b0;
        dinEol   = 1'b0;
    endtask

    task automatic sendLine();
        for (int i = 0; i < lineQ.size(); i++)
            applyStimulus(lineQ[i], i == 0, i == lineQ.size() - 1);
    endtask

    task automatic buildExp();
        expQ.delete();
        for (int i = 0; i < valQ.size(); i++)
            expQ.push_back({valQ[i], i == 0, i == valQ.size() - 1});
    endtask

    task automatic clearObs();
        obsMain.delete();
        obsSigned.delete();
        obsTrunc.delete();
    endtask

    task automatic checkLine(input string tag, input int which);
        logic [9:0] got[$];
        case (which)
            0:       got = obsMain;
            1:       got = obsSigned;
            default: got = obsTrunc;
        endcase
        checkOutput({tag, " count"}, 32'(got.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < got.size())
                checkOutput($sformatf("%s y[%0d]", tag, i), 32'(got[i]), 32'(expQ[i]));
        end
    endtask

    initial begin
        rst      = 1'b1;
        clkEn    = 1'b1;
        din      = 8'd0;
        dinValid = 1'b0;
        dinSol   = 1'b0;
        dinEol   = 1'b0;

        // Reset state
        #2;
        checkOutput("reset din_ready", 32'(dutReady), 32'd0);
        checkOutput("reset dout", 32'(dutOut), 32'd0);
        checkOutput("reset dout_valid", 32'(dutValid), 32'd0);
        checkOutput("reset sol/eol", 32'({dutSol, dutEol}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("ready after release", 32'(dutReady), 32'd1);

        // Constant line of 100, continuous valid, with timing checks
        clearObs();
        applyStimulus(8'd100, 1'b1, 1'b0);
        applyStimulus(8'd100, 1'b0, 1'b0);
        checkOutput("no output before p2", 32'(dutValid), 32'd0);
        applyStimulus(8'd100, 1'b0, 1'b0);
        checkOutput("first output valid", 32'(dutValid), 32'd1);
        checkOutput("first output value", 32'(dutOut), 32'd100);
        checkOutput("first output sol", 32'(dutSol), 32'd1);
        for (int i = 3; i < 7; i++) applyStimulus(8'd100, 1'b0, 1'b0);
        applyStimulus(8'd100, 1'b0, 1'b1);
        checkOutput("ready low flush1", 32'(dutReady), 32'd0);
        idle(1);
        checkOutput("ready low flush2", 32'(dutReady), 32'd0);
        idle(1);
        checkOutput("ready back high", 32'(dutReady), 32'd1);
        idle(3);
        valQ = '{100, 100, 100, 100, 100, 100, 100, 100};
        buildExp();
        checkLine("const", 0);
        valQ = '{8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hE4};
        buildExp();
        checkLine("const signed", 1);

        // Impulse line
        clearObs();
        lineQ = '{0, 0, 0, 160, 0, 0, 0};
        sendLine();
        idle(4);
        valQ = '{0, 10, 40, 60, 40, 10, 0};
        buildExp();
        checkLine("impulse", 0);

        // Single-pixel line
        clearObs();
        applyStimulus(8'd77, 1'b1, 1'b1);
        idle(4);
        valQ = '{77};
        buildExp();
        checkLine("n1", 0);

        // Two-pixel line, rounded and truncated
        clearObs();
        lineQ = '{0, 16};
        sendLine();
        idle(4);
        valQ = '{5, 11};
        buildExp();
        checkLine("n2", 0);
        checkLine("n2 trunc", 2);

        // Impulse line with clk_en toggling every cycle
        clearObs();
        toggleEn = 1'b1;
        lineQ = '{0, 0, 0, 160, 0, 0, 0};
        sendLine();
        idle(10);
        toggleEn = 1'b0;
        idle(2);
        valQ = '{0, 10, 40, 60, 40, 10, 0};
        buildExp();
        checkLine("toggle", 0);

        // Stray pixels without sol while idle
        clearObs();
        applyStimulus(8'd90, 1'b0, 1'b0);
        applyStimulus(8'd90, 1'b0, 1'b0);
        applyStimulus(8'd90, 1'b0, 1'b1);
        idle(4);
        checkOutput("stray count", 32'(obsMain.size()), 32'd0);

        // Line aborted by a new sol, then the new line
        clearObs();
        applyStimulus(8'd240, 1'b1, 1'b0);
        applyStimulus(8'd240, 1'b0, 1'b0);
        lineQ = '{0, 0, 0, 160, 0, 0, 0};
        sendLine();
        idle(4);
        valQ = '{0, 10, 40, 60, 40, 10, 0};
        buildExp();
        checkLine("restart", 0);

        // Asynchronous reset mid-line
        clearObs();
        applyStimulus(8'd200, 1'b1, 1'b0);
        applyStimulus(8'd200, 1'b0, 1'b0);
        applyStimulus(8'd200, 1'b0, 1'b0);
        checkOutput("pre-reset dout", 32'(dutOut), 32'd200);
        rst = 1'b1;
        #1;
        checkOutput("async reset dout", 32'(dutOut), 32'd0);
        checkOutput("async reset valid", 32'(dutValid), 32'd0);
        checkOutput("async reset signed dout", 32'(signedOut), 32'd0);
        idle(1);
        rst = 1'b0;
        clearObs();
        lineQ = '{0, 16};
        sendLine();
        idle(4);
        valQ = '{5, 11};
        buildExp();
        checkLine("after reset", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
